// File: rtl/ram_pkg.sv
// Shared types and default sizing for the parameterised dual-port RAM.
package ram_pkg;

  localparam int unsigned RAM_DEF_WIDTH = 40;
  localparam int unsigned RAM_DEF_DEPTH = 128;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_array_dp.sv
// Plain storage: one write port, one registered read port, no reset, so it
// maps onto a block RAM macro.
module ram_array_dp
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH = RAM_DEF_WIDTH,
  parameter int unsigned DEPTH = RAM_DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the pre-write content on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_dp_param.sv
// Dual-port RAM wrapper: clear-sweep FSM, request qualification, collision
// forwarding and the 1- or 2-cycle read pipeline around ram_array_dp.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH       = RAM_DEF_WIDTH,
  parameter int unsigned DEPTH       = RAM_DEF_DEPTH,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             WrEnable,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    AddressWR,
  input  logic             RdEnable,
  input  logic [AW-1:0]    AddressRD,
  input  logic             ClearReq,
  output logic [WIDTH-1:0] RdData,
  output logic             RdValid,
  output logic             BusyWR,
  output logic             BusyRD
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  ram_state_e       state, state_n;
  logic [AW-1:0]    ptr, ptr_n;
  logic             busy_q;

  logic             ready;
  logic             wr_in_range, rd_in_range;
  logic             wr_acc, rd_acc, collide, adv;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr, mem_raddr;
  logic [WIDTH-1:0] mem_wdata, ram_q;

  logic             v1, zero1, fwd1;
  logic [WIDTH-1:0] fwd_data1, d1;

  assign ready       = (state == READY);
  assign wr_in_range = ({1'b0, AddressWR} < DEPTH_W);
  assign rd_in_range = ({1'b0, AddressRD} < DEPTH_W);
  assign wr_acc      = ready & Enable & WrEnable & wr_in_range;
  assign rd_acc      = ready & Enable & RdEnable;
  assign collide     = wr_acc & rd_in_range & (AddressWR == AddressRD);
  // Pipeline freezes only on Enable=0 in READY; in-flight reads drain during CLEAR.
  assign adv         = Enable | ~ready;

  // During CLEAR the write port belongs to the sweep pointer.
  assign mem_we    = ~ready | wr_acc;
  assign mem_waddr = ready ? AddressWR : ptr;
  assign mem_wdata = ready ? WrData : '0;
  assign mem_raddr = rd_in_range ? AddressRD : '0;

  ram_array_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (Clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_acc),
    .raddr (mem_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= CLEAR;
      ptr    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      busy_q <= (state_n == CLEAR);
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      CLEAR: begin
        ptr_n = ptr + AW'(1);
        if (ptr == LAST_ADDR) begin
          state_n = READY;
          ptr_n   = '0;
        end
      end
      READY: begin
        if (ClearReq) begin
          state_n = CLEAR;
          ptr_n   = '0;
        end
      end
      default: begin
        state_n = CLEAR;
        ptr_n   = '0;
      end
    endcase
  end

  assign BusyWR = busy_q;
  assign BusyRD = busy_q;

  // Stage 1 sideband: out-of-range zeroing and write-first forwarding.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      v1        <= 1'b0;
      zero1     <= 1'b1;
      fwd1      <= 1'b0;
      fwd_data1 <= '0;
    end else begin
      if (adv) v1 <= rd_acc;
      if (rd_acc) begin
        zero1 <= ~rd_in_range;
        fwd1  <= collide & (WRITE_FIRST != 0);
        if (collide) fwd_data1 <= WrData;
      end
    end
  end

  assign d1 = zero1 ? '0 : (fwd1 ? fwd_data1 : ram_q);

  if (RD_LATENCY >= 2) begin : g_lat2
    logic             v2;
    logic [WIDTH-1:0] d2;

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (adv) begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign RdValid = v2;
    assign RdData  = d2;
  end else begin : g_lat1
    assign RdValid = v1;
    assign RdData  = d1;
  end

endmodule
